// File: rtl/square_unit_pkg.sv
// Shared definitions for the iterative squarer: FSM encoding and default root width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package square_unit_pkg;

    localparam int WIDTH_DEFAULT = 8;

    // 2'b11 is unused; the FSM steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/square_unit_cla.sv
// N-bit carry-lookahead adder built from 4-bit lookahead groups, rippling between groups.
// Latency: purely combinational.
// Backpressure: none.
module square_unit_cla #(
    parameter int N = 16            // must be a multiple of 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic [N-1:0] s_o,
    output logic         co_o
);

    logic [N-1:0] p;
    logic [N-1:0] g;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Each bit's carry is expanded from its group's carry-in and the
    // generate/propagate terms below it; k==4 produces the group carry-out.
    always_comb begin
        logic grp_c;
        logic ck;
        logic term;
        s_o   = '0;
        grp_c = ci_i;
        ck    = 1'b0;
        term  = 1'b0;
        for (int base = 0; base < N; base += 4) begin
            for (int k = 0; k <= 4; k++) begin
                ck = grp_c;
                for (int j = 0; j < k; j++) begin
                    ck = ck & p[base+j];
                end
                for (int j = 0; j < k; j++) begin
                    term = g[base+j];
                    for (int m = j + 1; m < k; m++) begin
                        term = term & p[base+m];
                    end
                    ck = ck | term;
                end
                if (k < 4) begin
                    s_o[base+k] = p[base+k] ^ ck;
                end else begin
                    grp_c = ck;
                end
            end
        end
        co_o = grp_c;
    end

endmodule

// File: rtl/square_unit.sv
// Iterative radix-2 shift-add squarer: W-bit root in, 2W-bit square out.
// Latency: ready_o rises exactly WIDTH edges after the edge that accepts start_i.
// Backpressure: start_i only accepted in IDLE/DONE; requests during CALC are dropped.
module square_unit
    import square_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT     // even, >= 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     root_i,
    output logic [2*WIDTH-1:0]   square_o,
    output logic                 busy_o,
    output logic                 ready_o
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [W2-1:0]      acc_q, acc_d;
    logic [W2-1:0]      mcand_q, mcand_d;
    logic [W2-1:0]      square_q, square_d;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [W2-1:0]      addend;
    logic [W2-1:0]      acc_sum;
    logic               add_co_unused;

    // Partial product for this iteration: the shifted multiplicand, gated by the current multiplier LSB.
    assign addend = mult_q[0] ? mcand_q : '0;

    // Accumulate adder; the square always fits in 2W bits so the carry-out is never needed.
    square_unit_cla #(.N(W2)) u_cla (
        .a_i  (acc_q),
        .b_i  (addend),
        .ci_i (1'b0),
        .s_o  (acc_sum),
        .co_o (add_co_unused)
    );

    // Next-state logic: load on accepted start, one shift-add per CALC edge, publish on the last one.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        cnt_d    = cnt_q;
        square_d = square_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    mcand_d = {{WIDTH{1'b0}}, root_i};
                    mult_d  = root_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Result register only ever sees the completed sum.
                    square_d = acc_sum;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mult_q   <= '0;
            cnt_q    <= '0;
            square_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            cnt_q    <= cnt_d;
            square_q <= square_d;
        end
    end

    assign square_o = square_q;
    assign busy_o   = (state_q == CALC);
    assign ready_o  = (state_q == DONE);

endmodule

// File: tb/tb_square_unit.sv
// Randomised and directed bench for square_unit with a queue-based scoreboard.
// Latency: checks ready_o arrives WIDTH edges after the accepting edge.
// Backpressure: exercises ignored starts during CALC and back-to-back held start.
module tb_square_unit;

    localparam int W  = 8;
    localparam int W2 = 2 * W;

    typedef struct {
        logic [W-1:0]  root;
        logic [W2-1:0] sq;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic [W-1:0]   root_i = '0;
    logic [W2-1:0]  square_o;
    logic           busy_o;
    logic           ready_o;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    square_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .root_i   (root_i),
        .square_o (square_o),
        .busy_o   (busy_o),
        .ready_o  (ready_o)
    );

    always #5 clk = ~clk;

    // Integer square root from first principles, for the round-trip check.
    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Wait for an accepting state, present the root, and record the expected square.
    task automatic issue(input logic [W-1:0] r, input bit hold);
        exp_t e;
        int guard = 0;
        while (busy_o && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("issue_wait_idle", busy_o, 0);
        start_i = 1'b1;
        root_i  = r;
        @(posedge clk);
        e.root = r;
        e.sq   = W2'(int'(r) * int'(r));
        exp_q.push_back(e);
        #1;
        if (!hold) start_i = 1'b0;
        root_i = W'($urandom);
    endtask

    // Count edges and busy cycles until ready_o; called at #1 after an edge.
    task automatic wait_done(input int exp_n);
        int n = 0;
        int n_busy = 0;
        while (n < 40) begin
            if (busy_o) n_busy++;
            if (ready_o) break;
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, exp_n);
        check("busy_cycles", n_busy, exp_n);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops the scoreboard on every new result and checks hold/exclusivity otherwise.
    logic          prev_ready = 1'b0;
    logic [W2-1:0] last_sq = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ready = 1'b0;
            last_sq    = '0;
        end else begin
            check("busy_ready_exclusive", busy_o & ready_o, 0);
            if (ready_o && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got square %0d with no request outstanding", square_o);
                end else begin
                    e = exp_q.pop_front();
                    check("square", square_o, e.sq);
                    check("sqrt_round_trip", isqrt(int'(square_o)), e.root);
                end
                last_sq = square_o;
            end else begin
                check("square_hold", square_o, last_sq);
            end
            prev_ready = ready_o;
        end
    end

    initial begin
        int saw_busy;

        // Reset state.
        idle_cycles(3);
        check("rst_square", square_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ready_o, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Zero root still takes the full latency.
        issue(8'd0, 1'b0);
        wait_done(W);

        // Maximum root.
        issue(8'd255, 1'b0);
        wait_done(W);

        // Result held across a DONE dwell, then replaced only at the new DONE.
        issue(8'd16, 1'b0);
        wait_done(W);
        idle_cycles(5);
        check("done_dwell_ready", ready_o, 1);
        issue(8'd13, 1'b0);
        check("ready_drops_after_restart", ready_o, 0);
        wait_done(W);

        // Start during CALC is ignored and does not queue.
        issue(8'd10, 1'b0);
        idle_cycles(2);
        start_i = 1'b1;
        root_i  = 8'd200;
        @(posedge clk); #1;
        start_i = 1'b0;
        root_i  = 8'd77;
        wait_done(W - 3);
        saw_busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (busy_o) saw_busy++;
        end
        check("no_queued_op", saw_busy, 0);

        // Asynchronous reset mid-CALC.
        issue(8'd200, 1'b0);
        idle_cycles(3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midcalc_rst_square", square_o, 0);
        check("midcalc_rst_busy", busy_o, 0);
        check("midcalc_rst_ready", ready_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(8'd3, 1'b0);
        wait_done(W);

        // Exhaustive back-to-back with start held high.
        for (int r = 0; r < 256; r++) begin
            issue(W'(r), 1'b1);
            wait_done(W);
        end
        start_i = 1'b0;
        idle_cycles(2);

        // Random roots with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            issue(W'($urandom), 1'b0);
            wait_done(W);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        idle_cycles(3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
